// File: rtl/mat_pkg.sv
// Shared constants, FSM encoding and helpers for the matrix datapath.
// Imported by the result streamer and, later, the operand loader.
package mat_pkg;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } mat_state_t;

    // Requested dimension forced into the supported 2..DIM range.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        logic [2:0] r;
        if (s < 3'd2) begin
            r = 3'd2;
        end else if (s > 3'(DIM)) begin
            r = 3'(DIM);
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/mat_elem_sel.sv
// Picks element (i,j) out of a packed DIM x DIM matrix; trans swaps the
// indices so the caller can walk positions row-major and read the transpose.
module mat_elem_sel
    import mat_pkg::*;
#(
    parameter int EW = ELEM_W,
    parameter int D  = DIM
) (
    input  logic [D*D*EW-1:0] mat,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    input  logic              trans,
    output logic [EW-1:0]     elem
);

    localparam int MW = D * D * EW;

    logic [EW-1:0] elems [D*D];
    logic [2:0]    src_row;
    logic [2:0]    src_col;
    logic [5:0]    idx;

    // Element (0,0) sits in the MSBs; flat index k = D*r + c.
    genvar gi;
    generate
        for (gi = 0; gi < D * D; gi++) begin : g_unpack
            assign elems[gi] = mat[MW-1-EW*gi -: EW];
        end
    endgenerate

    assign src_row = trans ? col : row;
    assign src_col = trans ? row : col;
    assign idx     = ({3'b000, src_row} * 6'(D)) + {3'b000, src_col};

    always_comb begin
        elem = '0;
        if (idx < 6'(D * D)) begin
            elem = elems[idx[4:0]];
        end
    end

endmodule

// File: rtl/mat_result_streamer.sv
// Captures the multiplier's product matrix and streams it out one element
// per valid/ready handshake, over an active size x size region.
module mat_result_streamer
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [MAT_W-1:0]  res_in,
    input  logic              ovf_in,
    input  logic              load,
    input  logic [2:0]        size,
    input  logic              trans,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_row,
    output logic [2:0]        out_col,
    output logic              out_last,
    output logic              ovf_out,
    output logic              busy,
    output logic              done
);

    mat_state_t       state_reg, state_next;
    logic [MAT_W-1:0] mat_reg,   mat_next;
    logic             ovf_reg,   ovf_next;
    logic [2:0]       size_reg,  size_next;
    logic             trans_reg, trans_next;
    logic [2:0]       row_reg,   row_next;
    logic [2:0]       col_reg,   col_next;

    logic             streaming;
    logic [2:0]       size_m1;
    logic             at_last;
    logic             row_end;
    logic [ELEM_W-1:0] sel_elem;

    assign streaming = (state_reg == ST_STREAM);
    assign size_m1   = size_reg - 3'd1;
    assign row_end   = (col_reg == size_m1);
    assign at_last   = row_end && (row_reg == size_m1);

    // Own copy of the matrix, so res_in may change while we stream.
    mat_elem_sel #(
        .EW (ELEM_W),
        .D  (DIM)
    ) u_sel (
        .mat   (mat_reg),
        .row   (row_reg),
        .col   (col_reg),
        .trans (trans_reg),
        .elem  (sel_elem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            mat_reg   <= '0;
            ovf_reg   <= 1'b0;
            size_reg  <= 3'd0;
            trans_reg <= 1'b0;
            row_reg   <= 3'd0;
            col_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            mat_reg   <= mat_next;
            ovf_reg   <= ovf_next;
            size_reg  <= size_next;
            trans_reg <= trans_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mat_next   = mat_reg;
        ovf_next   = ovf_reg;
        size_next  = size_reg;
        trans_next = trans_reg;
        row_next   = row_reg;
        col_next   = col_reg;

        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    mat_next   = res_in;
                    ovf_next   = ovf_in;
                    size_next  = clamp_size(size);
                    trans_next = trans;
                    row_next   = 3'd0;
                    col_next   = 3'd0;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // load is deliberately ignored here, including on the last edge.
                if (out_ready) begin
                    if (at_last) begin
                        row_next   = 3'd0;
                        col_next   = 3'd0;
                        state_next = ST_DONE;
                    end else if (row_end) begin
                        col_next = 3'd0;
                        row_next = row_reg + 3'd1;
                    end else begin
                        col_next = col_reg + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // All outputs derive from registered state; out_ready only steers the next state.
    assign out_valid = streaming;
    assign out_data  = streaming ? sel_elem : '0;
    assign out_row   = streaming ? row_reg : 3'd0;
    assign out_col   = streaming ? col_reg : 3'd0;
    assign out_last  = streaming && at_last;
    assign ovf_out   = ovf_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer: full, backpressured, transposed,
// clamped, load-while-busy and reset-abort streams against a reference walk.
module tb_mat_result_streamer;
    import mat_pkg::*;

    logic              clk;
    logic              rst;
    logic [MAT_W-1:0]  res_in;
    logic              ovf_in;
    logic              load;
    logic [2:0]        size;
    logic              trans;
    logic [ELEM_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_row;
    logic [2:0]        out_col;
    logic              out_last;
    logic              ovf_out;
    logic              busy;
    logic              done;

    logic [MAT_W-1:0]  base_mat;
    logic [MAT_W-1:0]  alt_mat;

    int n_checks = 0;
    int n_fails  = 0;

    mat_result_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .ovf_in    (ovf_in),
        .load      (load),
        .size      (size),
        .trans     (trans),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .ovf_out   (ovf_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One load, then walk the stream. sz_eff is the clamped size the bench
    // expects; rmode 1 drives ready 1,0,0,1; busy_load_at pulses a load with
    // other data at that transfer count; abort_after resets mid-stream.
    task automatic run_stream(input string name, input logic [2:0] sz_in, input int sz_eff,
                              input logic tr, input logic ovf, input int rmode,
                              input int busy_load_at, input logic done_load,
                              input int abort_after);
        int cnt;
        int cyc;
        int n;
        int r;
        int c;
        int exp_data;
        logic busy_loaded;
        logic [3:0] pat;
        pat = 4'b1001;
        n = sz_eff * sz_eff;
        busy_loaded = 1'b0;

        @(negedge clk);
        res_in = base_mat; ovf_in = ovf; size = sz_in; trans = tr; load = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_eq({name, "_valid_latency"}, 32'(out_valid), 32'd1);
        check_eq({name, "_ovf_out"}, 32'(ovf_out), 32'(ovf));

        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 400) begin
            out_ready = (rmode == 0) ? 1'b1 : pat[cyc % 4];
            if (cnt == busy_load_at && !busy_loaded) begin
                load = 1'b1;
                res_in = alt_mat;
                busy_loaded = 1'b1;
            end else begin
                load = 1'b0;
            end
            r = cnt / sz_eff;
            c = cnt % sz_eff;
            exp_data = tr ? (5 * c + r) : (5 * r + c);
            check_eq({name, "_valid"}, 32'(out_valid), 32'd1);
            check_eq({name, "_data"}, 32'(out_data), 32'(exp_data));
            check_eq({name, "_row"}, 32'(out_row), 32'(r));
            check_eq({name, "_col"}, 32'(out_col), 32'(c));
            check_eq({name, "_last"}, 32'(out_last), 32'(cnt == n - 1));
            check_eq({name, "_done_low"}, 32'(done), 32'd0);
            if (out_ready) begin
                $display("%s xfer %0d: row=%0d col=%0d data=%0d last=%0b ovf=%0b",
                         name, cnt, out_row, out_col, out_data, out_last, ovf_out);
                check_eq({name, "_ovf_hold"}, 32'(ovf_out), 32'(ovf));
                cnt++;
                if (cnt == abort_after) begin
                    @(posedge clk);
                    load = 1'b0;
                    #2;
                    rst = 1'b0;
                    #1;
                    check_eq({name, "_rst_valid"}, 32'(out_valid), 32'd0);
                    check_eq({name, "_rst_data"}, 32'(out_data), 32'd0);
                    check_eq({name, "_rst_row"}, 32'(out_row), 32'd0);
                    check_eq({name, "_rst_col"}, 32'(out_col), 32'd0);
                    check_eq({name, "_rst_last"}, 32'(out_last), 32'd0);
                    check_eq({name, "_rst_ovf"}, 32'(ovf_out), 32'd0);
                    check_eq({name, "_rst_busy"}, 32'(busy), 32'd0);
                    check_eq({name, "_rst_done"}, 32'(done), 32'd0);
                    @(negedge clk);
                    rst = 1'b1;
                    res_in = base_mat;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check_eq({name, "_abort_no_done"}, 32'(done), 32'd0);
                        check_eq({name, "_abort_idle"}, 32'(busy), 32'd0);
                    end
                    return;
                end
            end
            @(negedge clk);
            cyc++;
        end
        load = 1'b0;
        check_eq({name, "_transfer_count"}, 32'(cnt), 32'(n));

        // DONE cycle
        check_eq({name, "_done_valid"}, 32'(out_valid), 32'd0);
        check_eq({name, "_done_last"}, 32'(out_last), 32'd0);
        check_eq({name, "_done_pulse"}, 32'(done), 32'd1);
        check_eq({name, "_done_busy"}, 32'(busy), 32'd1);
        if (done_load) begin
            load = 1'b1;
            res_in = alt_mat;
        end
        @(negedge clk);
        load = 1'b0;
        check_eq({name, "_idle_done"}, 32'(done), 32'd0);
        check_eq({name, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        res_in = base_mat;
        @(negedge clk);
        check_eq({name, "_idle_valid2"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < DIM * DIM; k++) begin
            base_mat[MAT_W-1-ELEM_W*k -: ELEM_W] = 8'(k);
            alt_mat[MAT_W-1-ELEM_W*k -: ELEM_W]  = 8'(100 + k);
        end
        rst = 1'b0;
        res_in = base_mat;
        ovf_in = 1'b0;
        load = 1'b0;
        size = 3'd5;
        trans = 1'b0;
        out_ready = 1'b0;

        #3;
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_data", 32'(out_data), 32'd0);
        check_eq("reset_last", 32'(out_last), 32'd0);
        check_eq("reset_ovf", 32'(ovf_out), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_stream("full5", 3'd5, 5, 1'b0, 1'b0, 0, -1, 1'b0, -1);
        run_stream("bpress", 3'd5, 5, 1'b0, 1'b0, 1, -1, 1'b0, -1);
        run_stream("trans3", 3'd3, 3, 1'b1, 1'b0, 0, -1, 1'b0, -1);
        run_stream("clamp7", 3'd7, 5, 1'b0, 1'b1, 0, -1, 1'b0, -1);
        run_stream("clamp0", 3'd0, 2, 1'b0, 1'b0, 0, -1, 1'b0, -1);
        run_stream("ldbusy", 3'd5, 5, 1'b0, 1'b0, 0, 3, 1'b1, -1);
        run_stream("abort", 3'd5, 5, 1'b0, 1'b1, 0, -1, 1'b0, 7);
        run_stream("restart", 3'd5, 5, 1'b0, 1'b0, 0, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
- Output end of the matrix datapath: captures the packed 200-bit product matrix and its overflow flag from the 5x5 multiplier.
- Emits the result one signed 8-bit element per handshake toward the HPS-side register/FIFO interface.
- Supports an active sub-matrix size (2x2..5x5) and optional transposed readout.
- Holds its own copy of the matrix, so the multiplier inputs may change during readout.

Parameters:
- ELEM_W, 8, element width in bits (two's complement).
- DIM, 5, maximum matrix dimension; packed width MAT_W = DIM*DIM*ELEM_W = 200.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- res_in  in  MAT_W  packed result matrix. Element (r,c), 0-based, occupies bits [MAT_W-1-ELEM_W*(DIM*r+c) -: ELEM_W]. Element (0,0) is in the MSBs.
- ovf_in  in  1  overflow flag accompanying res_in.
- load  in  1  capture request; sampled only in IDLE.
- size  in  3  active dimension; sampled with load.
- trans  in  1  1 = emit transposed; sampled with load.
- out_data  out  ELEM_W  current element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the element.
- out_row  out  3  positional row of the current element.
- out_col  out  3  positional column of the current element.
- out_last  out  1  current element is the final one.
- ovf_out  out  1  latched overflow of the captured matrix.
- busy  out  1  high in STREAM and DONE.
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0. Matrix buffer, row/col pointers and latched size/trans cleared.
- Reset mid-stream aborts the stream immediately. No done pulse is generated.
- States: IDLE, STREAM, DONE.
- IDLE with load=1 at edge N:
  - Register res_in, ovf_in, trans and size into internal storage.
  - Clamp size: values 0..1 become 2; values 6..7 become 5.
  - Set row=col=0 and go to STREAM.
  - out_valid=1 from cycle N+1 (one-cycle latency).
  - ovf_out updates at N+1 and holds until the next accepted load or reset.
- STREAM:
  - out_valid=1.
  - out_data = element(row,col) of the buffer, or element(col,row) when the latched trans=1.
  - out_row/out_col always report the positional (row,col).
  - out_last=1 when row=size-1 and col=size-1.
- Handshake:
  - An element is transferred on an edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last stay stable.
  - out_ready may be high before out_valid and may toggle freely.
- Pointer advance on each transfer:
  - col increments.
  - When col=size-1: col wraps to 0 and row increments.
  - Order is row-major over the active size x size region only; exactly size*size transfers occur.
- Transfer of the out_last element:
  - Next state DONE; out_valid=0 and out_last=0.
  - done=1 for exactly the one DONE cycle, then IDLE.
  - busy falls in the same cycle as the IDLE entry.
- load in STREAM or DONE is ignored: no recapture, the stream is unaffected. A load must be reasserted in IDLE to be taken.
- load and the final transfer on the same edge: the load is ignored (state is STREAM at that edge).
- Elements are passed through unmodified. Zero-extension and sign handling are done downstream; out_data carries raw two's-complement bits.
- No combinational path from out_ready to out_valid. out_data may be combinational from registered state (buffer plus pointers).

Decomposition:
- Shared package mat_pkg:
  - ELEM_W, DIM, MAT_W.
  - State encoding constants ST_IDLE, ST_STREAM, ST_DONE.
  - A size-clamp function, reused by the future operand loader.
- One natural sub-module, mat_elem_sel: combinational selection of element (i,j) from the MAT_W buffer, with index swap when trans=1.
- Everything else (FSM, pointers, capture registers) stays in the top.

Test Plan:
1. Full 5x5, no transpose:
   - Stimulus: res_in element (r,c) = 5r+c (0..24), size=5, trans=0, out_ready held 1, one load pulse.
   - Required: 25 transfers with data 0..24 in order; out_last only on data 24; done pulse one cycle after it; busy low afterwards.
2. Backpressure:
   - Stimulus: as 1, with out_ready toggled 1,0,0,1 repeating.
   - Required: each element is held stable while out_ready=0; the sequence is still 0..24 with no duplicates or drops.
3. 3x3 transposed:
   - Stimulus: size=3, trans=1, same data.
   - Required: emitted data 0,5,10,1,6,11,2,7,12; out_row/out_col run (0,0)..(2,2) positionally; 9 transfers total.
4. Clamp and overflow:
   - Stimulus: size=7 with ovf_in=1, load; later size=0 with ovf_in=0, load.
   - Required: first stream has 25 transfers with ovf_out=1; second has 4 transfers (2x2: data 0,1,5,6) with ovf_out=0.
5. Load while busy:
   - Stimulus: during stream 1, pulse load with different res_in.
   - Required: the original data continues unchanged. A load in the DONE cycle is also ignored.
6. Reset mid-stream:
   - Stimulus: deassert rst (drive 0) after the 7th transfer.
   - Required: all outputs 0 immediately (asynchronous); no done pulse. A fresh load restarts from element (0,0).
